// File: rtl/mem_bus_master_if.sv
// Purpose: request/response handshake between the cache core and the line-transfer master, plus the bus line address.
// Latency: wires only; timing is owned by the modules on either side.
// Backpressure: req_valid/req_ready handshake; there is no backpressure on responses (resp_valid is a one-cycle pulse).
interface mem_bus_master_if #(
    parameter int LA     = 15,
    parameter int LINE_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [LA-1:0]     req_address;
    logic [LINE_W-1:0] req_line;
    logic              resp_valid;
    logic              resp_error;
    logic [LINE_W-1:0] resp_line;
    logic [LA-1:0]     mem_address;

    // Requester side (cache core).
    modport master (
        output req_valid, req_write, req_address, req_line,
        input  req_ready, resp_valid, resp_error, resp_line, mem_address
    );

    // Line-transfer master side.
    modport slave (
        input  req_valid, req_write, req_address, req_line,
        output req_ready, resp_valid, resp_error, resp_line, mem_address
    );
endinterface

// File: rtl/mem_bus_master.sv
// Purpose: runs one whole-line read or write as a burst on the shared tri-state memory bus and reports completion or timeout.
// Latency: write = BEATS driven cycles + wait for RESPONSE + 1; read = 1 READ cycle + wait + BEATS beats; responses are one-cycle pulses.
// Backpressure: req_ready is high only in IDLE; requests arriving while busy are ignored, not queued.
module mem_bus_master #(
    parameter int BUS_SIZE          = 16,
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int TIMEOUT           = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_master_if.slave      bus,
    inout  wire  [BUS_SIZE-1:0]  mem_data,
    inout  wire  [1:0]           mem_command
);
    localparam int LA     = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int LINE_W = CACHE_LINE_SIZE * 8;
    localparam int BEATS  = LINE_W / BUS_SIZE;
    localparam int BW     = $clog2(BEATS + 1);
    localparam int IDX_W  = $clog2(BEATS);
    localparam int WW     = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CMD_RESP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SEND,
        S_WR_WAIT,
        S_RD_REQ,
        S_RD_RECV,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LA-1:0]       r_addr;
    logic [LINE_W-1:0]   r_wr_line;
    logic [LINE_W-1:0]   r_rd_line;
    logic [LINE_W-1:0]   r_resp_line;
    logic [BW-1:0]       r_beat;
    logic [WW-1:0]       r_wait;
    logic                r_err;

    logic                w_resp_seen;
    logic                w_last_beat;
    logic                w_wait_expired;
    logic                w_finish_ok;
    logic                w_finish_err;
    logic [IDX_W-1:0]    w_beat_idx;
    logic [BUS_SIZE-1:0] w_wr_beat;
    logic [LINE_W-1:0]   w_rd_merged;
    logic                w_drive_wr;
    logic                w_drive_rd;

    assign w_resp_seen    = (mem_command == CMD_RESP);
    assign w_last_beat    = (r_beat == BW'(BEATS - 1));
    assign w_wait_expired = (r_wait == WW'(TIMEOUT - 1));
    assign w_beat_idx     = r_beat[IDX_W-1:0];

    // Select the write beat currently on the bus.
    always_comb begin
        w_wr_beat = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (w_beat_idx == IDX_W'(k)) begin
                w_wr_beat = r_wr_line[k*BUS_SIZE +: BUS_SIZE];
            end
        end
    end

    // Read line with the beat on the bus merged in, so the final beat and the response line update on the same edge.
    always_comb begin
        w_rd_merged = r_rd_line;
        for (int k = 0; k < BEATS; k++) begin
            if (w_beat_idx == IDX_W'(k)) begin
                w_rd_merged[k*BUS_SIZE +: BUS_SIZE] = mem_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and completion decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_finish_ok  = 1'b0;
        w_finish_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt = bus.req_write ? S_WR_SEND : S_RD_REQ;
                end
            end
            S_WR_SEND: begin
                if (w_last_beat) begin
                    w_state_nxt = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (w_resp_seen) begin
                    w_state_nxt = S_DONE;
                    w_finish_ok = 1'b1;
                end else if (w_wait_expired) begin
                    w_state_nxt  = S_DONE;
                    w_finish_err = 1'b1;
                end
            end
            S_RD_REQ: begin
                w_state_nxt = S_RD_RECV;
            end
            S_RD_RECV: begin
                if (w_resp_seen) begin
                    if (w_last_beat) begin
                        w_state_nxt = S_DONE;
                        w_finish_ok = 1'b1;
                    end
                end else if (r_beat != '0) begin
                    // Once a burst has started, any gap aborts the transfer.
                    w_state_nxt  = S_DONE;
                    w_finish_err = 1'b1;
                end else if (w_wait_expired) begin
                    w_state_nxt  = S_DONE;
                    w_finish_err = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch, beat/wait counters and read-line assembly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr    <= '0;
            r_wr_line <= '0;
            r_rd_line <= '0;
            r_beat    <= '0;
            r_wait    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr    <= bus.req_address;
                        r_wr_line <= bus.req_line;
                        r_beat    <= '0;
                    end
                end
                S_WR_SEND: begin
                    if (w_last_beat) begin
                        r_beat <= '0;
                        r_wait <= '0;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                S_WR_WAIT: begin
                    if (!w_resp_seen) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_RD_REQ: begin
                    r_beat <= '0;
                    r_wait <= '0;
                end
                S_RD_RECV: begin
                    if (w_resp_seen) begin
                        r_rd_line <= w_rd_merged;
                        r_beat    <= r_beat + 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Completion status; a good write leaves the previous response line untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err       <= 1'b0;
            r_resp_line <= '0;
        end else if (w_finish_err) begin
            r_err       <= 1'b1;
            r_resp_line <= '0;
        end else if (w_finish_ok) begin
            r_err <= 1'b0;
            if (r_state == S_RD_RECV) begin
                r_resp_line <= w_rd_merged;
            end
        end
    end

    // The bus is driven only while sending write beats or the read command; otherwise released.
    assign w_drive_wr  = (r_state == S_WR_SEND);
    assign w_drive_rd  = (r_state == S_RD_REQ);
    assign mem_command = w_drive_wr ? CMD_WRITE : (w_drive_rd ? CMD_READ : 2'bzz);
    assign mem_data    = w_drive_wr ? w_wr_beat : {BUS_SIZE{1'bz}};

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.resp_valid  = (r_state == S_DONE);
    assign bus.resp_error  = (r_state == S_DONE) && r_err;
    assign bus.resp_line   = r_resp_line;
    assign bus.mem_address = r_addr;
endmodule

// File: tb/tb_mem_bus_master.sv
// Purpose: scoreboard bench for mem_bus_master with a simple responding memory model on the tri-state bus.
// Latency: checks exact cycle placement of bus drive, release, resp_valid and re-acceptance.
// Backpressure: requests are only presented when req_ready is high, except the held-valid back-to-back case.
module tb_mem_bus_master;
    logic clk;
    logic reset;

    wire [15:0] mem_data;
    wire [1:0]  mem_command;
    logic       tb_en;
    logic [1:0] tb_cmd;
    logic [15:0] tb_dat;

    // Memory-side model drive; pulls make a released bus read as NOP command and all-ones data.
    assign mem_command = tb_en ? tb_cmd : 2'bzz;
    assign mem_data    = tb_en ? tb_dat : 16'hzzzz;
    pulldown (mem_command);
    pullup (mem_data);

    mem_bus_master_if #(.LA(15), .LINE_W(128)) bus ();

    mem_bus_master #(
        .BUS_SIZE(16), .MEM_ADDR_SIZE(19), .CACHE_OFFSET_SIZE(4),
        .CACHE_LINE_SIZE(16), .TIMEOUT(255)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .mem_data(mem_data), .mem_command(mem_command)
    );

    typedef struct packed {
        logic         err;
        logic [127:0] line;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every completion pulse pops one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("resp_error", bus.resp_error, e.err);
                chk("resp_line", bus.resp_line, e.line);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_beat(input logic [15:0] d);
        tb_en  = 1'b1;
        tb_cmd = 2'd1;
        tb_dat = d;
    endtask

    task automatic issue(input logic wr, input logic [14:0] addr, input logic [127:0] line, input logic hold);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_issue", bus.req_ready, 1'b1);
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_address = addr;
        bus.req_line    = line;
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic chk_released(input string tag);
        chk({tag, "_cmd_z"}, mem_command, 2'd0);
        chk({tag, "_dat_z"}, mem_data, 16'hFFFF);
    endtask

    logic [127:0] l_rd1, l_rd2, l_wr1, l_wr2;
    int bad, early;

    initial begin
        l_wr1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        l_wr2 = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
        for (int k = 0; k < 8; k++) begin
            l_rd1[k*16 +: 16] = 16'(k);
            l_rd2[k*16 +: 16] = 16'hA000 + 16'(k);
        end
        reset           = 1'b0;
        tb_en           = 1'b0;
        tb_cmd          = 2'd0;
        tb_dat          = 16'd0;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_address = '0;
        bus.req_line    = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_error", bus.resp_error, 1'b0);
        chk("rst_resp_line", bus.resp_line, '0);
        chk("rst_mem_address", bus.mem_address, '0);
        chk_released("rst");
        reset = 1'b1;

        // Read 0x7FFF, answered after a long wait.
        sb.push_back('{err: 1'b0, line: l_rd1});
        issue(1'b0, 15'h7FFF, '0, 1'b0);
        @(negedge clk);
        chk("rd_cmd", mem_command, 2'd2);
        chk("rd_addr", bus.mem_address, 15'h7FFF);
        chk("rd_ready_busy", bus.req_ready, 1'b0);
        bad = 0;
        for (int j = 1; j < 100; j++) begin
            @(negedge clk);
            if (mem_command !== 2'd0 || mem_data !== 16'hFFFF || bus.resp_valid !== 1'b0) bad++;
        end
        chk("rd_wait_released", bad, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive_beat(16'(k));
        end
        @(posedge clk);
        #1 tb_en = 1'b0;
        @(negedge clk);
        chk("rd_resp_valid", bus.resp_valid, 1'b1);

        // Write 0x0005; a good write leaves resp_line at the previous read line.
        sb.push_back('{err: 1'b0, line: l_rd1});
        issue(1'b1, 15'h0005, l_wr1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("wr_cmd", mem_command, 2'd3);
            chk("wr_dat", mem_data, l_wr1[k*16 +: 16]);
        end
        chk("wr_addr", bus.mem_address, 15'h0005);
        @(negedge clk);
        chk_released("wr_wait");
        chk("wr_ready_busy", bus.req_ready, 1'b0);
        repeat (2) @(negedge clk);
        drive_beat(16'h0);
        @(posedge clk);
        #1 tb_en = 1'b0;
        @(negedge clk);
        chk("wr_resp_valid", bus.resp_valid, 1'b1);
        chk("wr_done_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        chk("wr_pulse_len", bus.resp_valid, 1'b0);
        chk("wr_idle_ready", bus.req_ready, 1'b1);

        // Read with no answer: timeout after exactly 255 released cycles.
        sb.push_back('{err: 1'b1, line: '0});
        issue(1'b0, 15'h0123, '0, 1'b0);
        @(negedge clk);
        chk("to_rd_cmd", mem_command, 2'd2);
        bad   = 0;
        early = 0;
        for (int j = 1; j <= 255; j++) begin
            @(negedge clk);
            if (mem_command !== 2'd0 || mem_data !== 16'hFFFF) bad++;
            if (bus.resp_valid !== 1'b0) early++;
        end
        chk("to_bus_released", bad, 0);
        chk("to_no_early_resp", early, 0);
        @(negedge clk);
        chk("to_resp_valid", bus.resp_valid, 1'b1);
        chk("to_resp_error", bus.resp_error, 1'b1);

        // Read with a gap after beat 3.
        sb.push_back('{err: 1'b1, line: '0});
        issue(1'b0, 15'h0042, '0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_beat(16'h5500 + 16'(k));
        end
        @(posedge clk);
        #1 tb_en = 1'b0;
        @(negedge clk);
        chk("gap_not_yet", bus.resp_valid, 1'b0);
        @(negedge clk);
        chk("gap_resp_valid", bus.resp_valid, 1'b1);
        chk("gap_resp_error", bus.resp_error, 1'b1);

        // Back-to-back write then read with req_valid held high.
        sb.push_back('{err: 1'b0, line: '0});
        sb.push_back('{err: 1'b0, line: l_rd2});
        issue(1'b1, 15'h0ABC, l_wr2, 1'b1);
        bad = 0;
        @(negedge clk);
        if (bus.req_ready !== 1'b0) bad++;
        bus.req_write   = 1'b0;
        bus.req_address = 15'h1234;
        repeat (9) begin
            @(negedge clk);
            if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) bad++;
        end
        drive_beat(16'h0);
        @(posedge clk);
        #1 tb_en = 1'b0;
        @(negedge clk);
        chk("b2b_wr_resp_valid", bus.resp_valid, 1'b1);
        chk("b2b_done_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        chk("b2b_idle_ready", bus.req_ready, 1'b1);
        chk("b2b_idle_resp", bus.resp_valid, 1'b0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rd_cmd", mem_command, 2'd2);
        chk("b2b_rd_addr", bus.mem_address, 15'h1234);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.req_ready !== 1'b0) bad++;
            drive_beat(l_rd2[k*16 +: 16]);
        end
        @(posedge clk);
        #1 tb_en = 1'b0;
        @(negedge clk);
        chk("b2b_rd_resp_valid", bus.resp_valid, 1'b1);
        chk("b2b_ready_low", bad, 0);

        // Asynchronous reset during beat 4 of a read; the request is dropped.
        issue(1'b0, 15'h0077, '0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_beat(16'h7700 + 16'(k));
        end
        #2;
        reset = 1'b0;
        tb_en = 1'b0;
        #1;
        chk("arst_req_ready", bus.req_ready, 1'b1);
        chk("arst_resp_valid", bus.resp_valid, 1'b0);
        chk("arst_resp_line", bus.resp_line, '0);
        chk("arst_mem_address", bus.mem_address, '0);
        chk_released("arst");
        early = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) early++;
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) early++;
        end
        chk("arst_no_resp", early, 0);

        // A normal write after reset.
        sb.push_back('{err: 1'b0, line: '0});
        issue(1'b1, 15'h0009, l_wr1, 1'b0);
        @(negedge clk);
        chk("post_rst_wr_cmd", mem_command, 2'd3);
        chk("post_rst_wr_dat", mem_data, 16'h6677);
        repeat (8) @(negedge clk);
        drive_beat(16'h0);
        @(posedge clk);
        #1 tb_en = 1'b0;
        @(negedge clk);
        chk("post_rst_resp_valid", bus.resp_valid, 1'b1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Line-transfer controller on the memory side of the cache. It accepts one whole-line read or write request from the cache core through a valid/ready handshake. It runs the request as a burst on the shared 2-bit-command memory bus (address, bidirectional data, bidirectional command) toward `mem`, and returns the read line or write acknowledge together with a timeout error flag.

## Interface
- `BUS_SIZE`, 16: data bus width in bits.
- `MEM_ADDR_SIZE`, 19: byte address width.
- `CACHE_OFFSET_SIZE`, 4: line offset width; line address width `LA = MEM_ADDR_SIZE-CACHE_OFFSET_SIZE` (15).
- `CACHE_LINE_SIZE`, 16: line size in bytes; `LINE_W = CACHE_LINE_SIZE*8` (128), `BEATS = LINE_W/BUS_SIZE` (8).
- `TIMEOUT`, 255: maximum idle wait cycles before error; must be at least 1.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = write line, 0 = read line.
- `req_address`  in  LA  line address.
- `req_line`  in  LINE_W  write data; beat k = bits `[k*BUS_SIZE +: BUS_SIZE]`.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_error`  out  1  completion was a timeout or burst gap; qualified by `resp_valid`.
- `resp_line`  out  LINE_W  read line; valid with `resp_valid` on a read.
- `mem_address`  out  LA  bus line address.
- `mem_data`  inout  BUS_SIZE  bus data; high-Z when not driven.
- `mem_command`  inout  2  bus command: 0 NOP, 1 RESPONSE, 2 READ, 3 WRITE; high-Z when not driven.

## Operation
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_error`=0, `resp_line`=0, `mem_address`=0. `mem_data` and `mem_command` are released (Z). State is IDLE; beat counter and wait counter are 0.
- States: IDLE, WR_SEND, WR_WAIT, RD_REQ, RD_RECV, DONE.
- IDLE: `req_ready`=1. When `req_valid` is 1 at posedge, latch address, write flag and line. Go to WR_SEND if writing, otherwise RD_REQ.
- WR_SEND: drive `mem_command`=WRITE, `mem_address`, and `mem_data`=beat k for k=0..BEATS-1, one beat per cycle. After beat BEATS-1, go to WR_WAIT.
- WR_WAIT: bus released. If `mem_command`==RESPONSE is sampled, go to DONE with no error. Otherwise increment the wait counter. When the counter reaches TIMEOUT, go to DONE with error.
- RD_REQ: one cycle driving `mem_command`=READ and `mem_address`, then go to RD_RECV.
- RD_RECV: bus released. Before the first beat, waiting and timeout work as in WR_WAIT. Each sampled RESPONSE stores `mem_data` into beat k, then k increments. After beat BEATS-1, go to DONE. After the first beat, beats must be consecutive: a cycle without RESPONSE means go to DONE with error.
- DONE: `resp_valid`=1 for exactly one cycle, `req_ready`=0, then go to IDLE.
  - On error, `resp_error`=1 and `resp_line`=0.
  - On a good read, `resp_line` is the assembled line.
  - On a good write, `resp_line` is unchanged.
- `req_ready`=0 in every state except IDLE. Requests there are ignored, not queued.
- RESPONSE seen while driving the bus (WR_SEND/RD_REQ) is ignored.
- Counters are sized to hold TIMEOUT and BEATS with no wrap. The wait counter clears on entry to WR_WAIT/RD_RECV.

## Timing
- `req_ready` and `resp_valid` come from registered state, not combinationally from inputs.
- Request accepted at edge T. The first driven bus cycle is T..T+1.
- Write: WRITE is driven for BEATS cycles (T..T+8). The bus is released from edge T+8. If RESPONSE is sampled at edge A, `resp_valid` is high A..A+1, and a new request can be accepted at edge A+2.
- Read: READ is driven for one cycle. If the last beat is sampled at edge B, `resp_valid` is high B..B+1.
- Timeout: error at exactly TIMEOUT released cycles without RESPONSE.
- Asynchronous reset mid-transfer: the bus is released immediately, and all outputs and state return to reset values. The in-flight request is dropped and gets no response.

## Test plan
- Write line 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to address 0x0005 -> 8 WRITE cycles with data 0x6677, 0x4455, …, 0x0123 and address 0x0005. After RESPONSE, one `resp_valid` pulse with `resp_error`=0.
- Read address 0x7FFF, model answers after 100 cycles with beats 0x0000..0x0007 -> one READ cycle; `resp_line`=0x0007_0006_…_0000, `resp_error`=0.
- Read with no answer -> `resp_valid` with `resp_error`=1 and `resp_line`=0 after 255 released cycles. The bus is Z throughout the wait.
- Read with a 1-cycle gap after beat 3 -> error completion at the gap cycle, `resp_line`=0.
- Back-to-back write then read with `req_valid` held high -> second request accepted 1 cycle after the first `resp_valid`. `req_ready`=0 throughout each transfer.
- Reset pulled low during beat 4 of RD_RECV -> outputs at reset values immediately and the bus is Z. No `resp_valid` appears. The next request completes normally.
